// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial arithmetic family (adder now, subtractor planned).
// Holds the FSM state encodings and the majority function used by the carry logic.
package serial_adder_pkg;

    typedef logic [1:0] sa_state_t;

    localparam sa_state_t IDLE = 2'd0;
    localparam sa_state_t RUN  = 2'd1;
    localparam sa_state_t DONE = 2'd2;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell, purely combinational.
// Port style matches the full subtractor cell so the two can be swapped in the family.
module full_adder
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = maj(a, b, cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder cell and a carry flip-flop process operands LSB first.
// The parallel result and carry-out are published together with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_sa,
    input  logic [WIDTH-1:0] a_sa,
    input  logic [WIDTH-1:0] b_sa,
    input  logic             cin_sa,
    output logic             busy_sa,
    output logic             done_sa,
    output logic [WIDTH-1:0] sum_sa,
    output logic             cout_sa
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        state;
    sa_state_t        next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] next_res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;

    full_adder u_full_adder (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = start_sa && ((state == IDLE) || (state == DONE));
    assign last_bit = (state == RUN) && (cnt == LAST);

    // The result register keeps only the upper WIDTH-1 bits; the newest sum bit
    // completes the word on the final RUN cycle.
    assign next_res = {fa_sum, res_sh};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_sa) next_state = RUN;
            RUN:     if (cnt == LAST) next_state = DONE;
            DONE:    next_state = start_sa ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_sa = (state == RUN);
        done_sa = (state == DONE);
    end

    // Datapath: operands shift right under the adder cell; sum_sa/cout_sa only
    // change on the last bit so intermediate shifting stays hidden.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum_sa  <= '0;
            cout_sa <= 1'b0;
        end else if (accept) begin
            a_sh  <= a_sa;
            b_sh  <= b_sa;
            carry <= cin_sa;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= next_res[WIDTH-1:1];
            carry  <= fa_cout;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                sum_sa  <= next_res;
                cout_sa <= fa_cout;
            end
        end
    end

endmodule
